// File: rtl/lfsr_core.sv
// lfsr_core: parameterised Fibonacci LFSR used as a pseudo-random stimulus/noise source.
//
// Parameters
//   N          register width, legal 2..32; selects a maximal-length XOR tap set
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; forces num = 1
//   load_seed  synchronous seed load strobe (level, sampled every edge)
//   rand_bus   [17:1] shared seed bus; rand_bus[N:1] used, zero-extended when N > 17.
//              Named rand_bus because "rand" is a reserved SystemVerilog keyword.
//   num        [N:1] registered LFSR state; the serial output bit is num[1]
//
// Build option
//   LFSR_ZERO_GUARD_EN  when defined, the all-zero lock-up state is never entered:
//                       a zero seed loads 1, and a zero state shifts to 1.
module lfsr_core #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_seed,
  input  logic [17:1] rand_bus,
  output logic [N:1]  num
);

  // Out-of-range widths stop elaboration on the missing module below.
  generate
    if (N < 2 || N > 32) begin : g_illegal_n
      lfsr_core_illegal_width_n u_illegal ();
    end
  endgenerate

  // Maximal-length tap masks; bit (i-1) of the mask selects num[i].
  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    m = 32'h0;
    case (n)
      2:  m = 32'h0000_0003; // 2,1
      3:  m = 32'h0000_0006; // 3,2
      4:  m = 32'h0000_000C; // 4,3
      5:  m = 32'h0000_0014; // 5,3
      6:  m = 32'h0000_0030; // 6,5
      7:  m = 32'h0000_0060; // 7,6
      8:  m = 32'h0000_00B8; // 8,6,5,4
      9:  m = 32'h0000_0110; // 9,5
      10: m = 32'h0000_0240; // 10,7
      11: m = 32'h0000_0500; // 11,9
      12: m = 32'h0000_0829; // 12,6,4,1
      13: m = 32'h0000_100D; // 13,4,3,1
      14: m = 32'h0000_2015; // 14,5,3,1
      15: m = 32'h0000_6000; // 15,14
      16: m = 32'h0000_D008; // 16,15,13,4
      17: m = 32'h0001_2000; // 17,14
      18: m = 32'h0002_0400; // 18,11
      19: m = 32'h0004_0023; // 19,6,2,1
      20: m = 32'h0009_0000; // 20,17
      21: m = 32'h0014_0000; // 21,19
      22: m = 32'h0030_0000; // 22,21
      23: m = 32'h0042_0000; // 23,18
      24: m = 32'h00E1_0000; // 24,23,22,17
      25: m = 32'h0120_0000; // 25,22
      26: m = 32'h0200_0023; // 26,6,2,1
      27: m = 32'h0400_0013; // 27,5,2,1
      28: m = 32'h0900_0000; // 28,25
      29: m = 32'h1400_0000; // 29,27
      30: m = 32'h2000_0029; // 30,6,4,1
      31: m = 32'h4800_0000; // 31,28
      32: m = 32'h8020_0003; // 32,22,2,1
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  localparam logic [31:0] TAPS = tap_mask(N);
  localparam logic [N:1]  ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N:1]  mask;
  logic        feedback;   // probed hierarchically; keep this name
  logic [32:1] rand_ext;
  logic [N:1]  seed;
  logic        unused_bits;

  assign mask     = TAPS[N-1:0];
  assign feedback = ^(num & mask);

  // Zero-extend the 17-bit bus to the widest legal N, then take the low N bits.
  assign rand_ext    = {15'd0, rand_bus};
  assign seed        = rand_ext[N:1];
  assign unused_bits = ^rand_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num <= ONE;
    end else if (load_seed) begin
`ifdef LFSR_ZERO_GUARD_EN
      num <= (seed == '0) ? ONE : seed;
`else
      num <= seed;
`endif
    end else begin
`ifdef LFSR_ZERO_GUARD_EN
      num <= (num == '0) ? ONE : {num[N-1:1], feedback};
`else
      num <= {num[N-1:1], feedback};
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_core.sv
// tb_lfsr_core: directed bench for lfsr_core with an N=8 and an N=17 instance
// sharing one seed bus and load strobe.
module tb_lfsr_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_seed;
  logic [16:0] rand_bus;
  logic [7:0]  n8;
  logic [16:0] n17;

  int passed = 0;
  int total  = 0;

  lfsr_core #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .load_seed(load_seed), .rand_bus(rand_bus), .num(n8)
  );
  lfsr_core #(.N(17)) dut17 (
    .clk(clk), .rst(rst), .load_seed(load_seed), .rand_bus(rand_bus), .num(n17)
  );

  always #5 clk = ~clk;

  // Reference next-state functions written straight from the tap lists.
  function automatic logic [7:0] m8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction
  function automatic logic [16:0] m17(input logic [16:0] x);
    return {x[15:0], x[16] ^ x[13]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0]  e8;
  logic [16:0] e17;
  int per, dups, bad8, bad17, badfb, distinct, zeros;
  bit seen [256];

  initial begin
    rst = 1'b1; load_seed = 1'b0; rand_bus = 17'h0;
    #2;
    chk("reset_n8", n8, 32'h01);
    chk("reset_n17", n17, 32'h00001);
    step(); step();
    chk("reset_hold_n8", n8, 32'h01);
    #2 rst = 1'b0;
    step();
    chk("first_shift_n8", n8, 32'h02);
    chk("first_shift_n17", n17, 32'h00002);
    step(); step();

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("async_rst_n8", n8, 32'h01);
    chk("async_rst_n17", n17, 32'h00001);
    #1 rst = 1'b0;
    step();
    chk("post_rst_shift_n8", n8, 32'h02);

    // Seed load and first shift with zero feedback.
    rand_bus = 17'h000A5; load_seed = 1'b1;
    step();
    chk("load_a5_n8", n8, 32'hA5);
    chk("load_a5_n17", n17, 32'h000A5);
    chk("fb_a5", {31'd0, dut8.feedback}, 32'h0);
    load_seed = 1'b0;
    step();
    chk("shift_a5_n8", n8, 32'h4A);
    chk("shift_a5_n17", n17, 32'h0014A);

    // rand changes with load_seed low must not disturb the sequence.
    e8 = 8'h4A; e17 = 17'h0014A; bad8 = 0; bad17 = 0;
    for (int i = 0; i < 20; i++) begin
      rand_bus = 17'($urandom);
      step();
      e8 = m8(e8); e17 = m17(e17);
      if (n8 !== e8) bad8++;
      if (n17 !== e17) bad17++;
    end
    chk("rand_ignored_n8", bad8, 0);
    chk("rand_ignored_n17", bad17, 0);

    // load_seed held high reloads every edge.
    rand_bus = 17'h1003C; load_seed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_load_n8", n8, 32'h3C);
      chk("hold_load_n17", n17, 32'h1003C);
    end

    // Reset wins over load_seed; first edge after release loads.
    rand_bus = 17'h0005A;
    #2 rst = 1'b1;
    #1;
    chk("rst_over_load_n8", n8, 32'h01);
    step();
    chk("rst_held_edge_n8", n8, 32'h01);
    chk("rst_held_edge_n17", n17, 32'h00001);
    #2 rst = 1'b0;
    step();
    chk("load_after_rst_n8", n8, 32'h5A);
    chk("load_after_rst_n17", n17, 32'h0005A);
    load_seed = 1'b0;

    // Full N=8 period from reset; N=17 tracked against its tap model.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    per = 0; dups = 0; bad8 = 0; bad17 = 0; badfb = 0;
    e8 = 8'h01; e17 = 17'h00001;
    for (int i = 0; i < 300; i++) begin
      step();
      per++;
      e8 = m8(e8); e17 = m17(e17);
      if (n8 !== e8) bad8++;
      if (n17 !== e17) bad17++;
      if (dut17.feedback !== (n17[16] ^ n17[13])) badfb++;
      if (seen[n8]) dups++;
      seen[n8] = 1'b1;
      if (n8 == 8'h01) break;
    end
    distinct = 0;
    for (int v = 0; v < 256; v++) if (seen[v]) distinct++;
    chk("period_n8", per, 255);
    chk("period_dups_n8", dups, 0);
    chk("period_distinct_n8", distinct, 255);
    chk("period_no_zero_n8", {31'd0, seen[0]}, 0);
    chk("model_n8", bad8, 0);
    chk("model_n17", bad17, 0);
    chk("feedback_n17", badfb, 0);

    // All-zero seed.
    rand_bus = 17'h0; load_seed = 1'b1;
    step();
    load_seed = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    chk("zero_seed_n8", n8, 32'h01);
    chk("zero_seed_n17", n17, 32'h00001);
    step();
    chk("zero_seed_shift_n8", n8, 32'h02);
    chk("zero_seed_shift_n17", n17, 32'h00002);
`else
    chk("zero_seed_n8", n8, 32'h00);
    chk("zero_seed_n17", n17, 32'h00000);
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (n8 === 8'h00 && n17 === 17'h0) zeros++;
    end
    chk("zero_lockup", zeros, 10);
`endif

    // Mid-run reset pulse on both widths, then resume.
    rand_bus = 17'h1ACE1; load_seed = 1'b1;
    step();
    load_seed = 1'b0;
    chk("reseed_n8", n8, 32'hE1);
    chk("reseed_n17", n17, 32'h1ACE1);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("pulse_n8", n8, 32'h01);
    chk("pulse_n17", n17, 32'h00001);
    #1 rst = 1'b0;
    step();
    chk("resume_n8", n8, 32'h02);
    chk("resume_n17", n17, 32'h00002);
    e8 = 8'h02; e17 = 17'h00002; bad8 = 0; bad17 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      e8 = m8(e8); e17 = m17(e17);
      if (n8 !== e8) bad8++;
      if (n17 !== e17) bad17++;
    end
    chk("resume_model_n8", bad8, 0);
    chk("resume_model_n17", bad17, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
